fft_cbfp_denorm: RTL and testbench

//  Inverse of the stage CBFP normalizer: restores 12-bit block-floating mantissas to full

---
 rtl/fft_cbfp_denorm.sv | 152 +++++++++++++++
 tb/tb_fft_cbfp_denorm.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_cbfp_denorm.sv
// CBFP de-normalizer: restores block-floating mantissas to full fixed-point scale using
// per-sample shift indices held in a two-bank ping-pong index store.
module fft_cbfp_denorm #(
  parameter int WIDTH_IN  = 12,
  parameter int WIDTH_OUT = 25,
  parameter int ARRAY_IN  = 16,
  parameter int BEATS     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        idx_valid,
  output logic                        idx_ready,
  input  logic [4:0]                  idx_in [0:ARRAY_IN-1],
  input  logic                        din_valid,
  output logic                        din_ready,
  input  logic signed [WIDTH_IN-1:0]  din_i  [0:ARRAY_IN-1],
  input  logic signed [WIDTH_IN-1:0]  din_q  [0:ARRAY_IN-1],
  output logic                        dout_valid,
  output logic signed [WIDTH_OUT-1:0] dout_i [0:ARRAY_IN-1],
  output logic signed [WIDTH_OUT-1:0] dout_q [0:ARRAY_IN-1],
  output logic                        din_drop,
  output logic                        dbg_rd_state
);
  localparam int         CW        = $clog2(BEATS);
  localparam logic [4:0] IDX_UNITY = 5'(WIDTH_OUT - WIDTH_IN);
  localparam logic [4:0] IDX_CLAMP = 5'(WIDTH_OUT - WIDTH_IN + WIDTH_IN - 1);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_t;
  typedef enum logic {RD_IDLE = 1'b0, RD_RUN = 1'b1} rd_state_t;

  bank_t            r_bank_st [0:1];
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [CW-1:0]    r_wr_cnt;
  logic [CW-1:0]    r_rd_cnt;
  rd_state_t        r_rd_state;
  logic [4:0]       r_mem [0:1][0:BEATS-1][0:ARRAY_IN-1];
  logic [4:0]       w_rd_idx [0:ARRAY_IN-1];
  logic             w_idx_acc;
  logic             w_din_acc;

  logic                       r_s1_valid;
  logic signed [WIDTH_IN-1:0] r_s1_i   [0:ARRAY_IN-1];
  logic signed [WIDTH_IN-1:0] r_s1_q   [0:ARRAY_IN-1];
  logic [4:0]                 r_s1_idx [0:ARRAY_IN-1];

  // Both input streams: a beat transfers on a rising edge where valid and ready are both
  // high; ready is a function of registered state only, never of the matching valid.
  assign idx_ready    = (r_bank_st[r_wr_bank] == B_EMPTY) || (r_bank_st[r_wr_bank] == B_FILLING);
  assign din_ready    = (r_rd_state == RD_RUN);
  assign dbg_rd_state = r_rd_state;
  assign w_idx_acc    = idx_valid & idx_ready;
  assign w_din_acc    = din_valid & din_ready;

  // Write and read never touch the same bank in one cycle: a bank being drained is not writable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank_st[0] <= B_EMPTY;
      r_bank_st[1] <= B_EMPTY;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_wr_cnt     <= '0;
      r_rd_cnt     <= '0;
      r_rd_state   <= RD_IDLE;
    end else begin
      if (w_idx_acc) begin
        if (r_wr_cnt == CW'(BEATS - 1)) begin
          r_bank_st[r_wr_bank] <= B_FULL;
          r_wr_cnt             <= '0;
          r_wr_bank            <= ~r_wr_bank;
        end else begin
          r_bank_st[r_wr_bank] <= B_FILLING;
          r_wr_cnt             <= r_wr_cnt + 1'b1;
        end
      end
      case (r_rd_state)
        RD_IDLE: begin
          if (r_bank_st[r_rd_bank] == B_FULL) begin
            r_bank_st[r_rd_bank] <= B_DRAINING;
            r_rd_state           <= RD_RUN;
          end
        end
        RD_RUN: begin
          if (w_din_acc) begin
            if (r_rd_cnt == CW'(BEATS - 1)) begin
              r_bank_st[r_rd_bank] <= B_EMPTY;
              r_rd_cnt             <= '0;
              r_rd_bank            <= ~r_rd_bank;
              r_rd_state           <= RD_IDLE;
            end else begin
              r_rd_cnt <= r_rd_cnt + 1'b1;
            end
          end
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_idx_acc) begin
      for (int k = 0; k < ARRAY_IN; k++) r_mem[r_wr_bank][r_wr_cnt][k] <= idx_in[k];
    end
  end

  always_comb begin
    for (int k = 0; k < ARRAY_IN; k++) w_rd_idx[k] = r_mem[r_rd_bank][r_rd_cnt][k];
  end

  // Index IDX_UNITY means unity gain; larger indices shift right, flooring toward -inf.
  function automatic logic signed [WIDTH_OUT-1:0] restore(
    input logic signed [WIDTH_IN-1:0] m,
    input logic [4:0]                 idx
  );
    logic signed [WIDTH_OUT-1:0] ext;
    ext = {{(WIDTH_OUT - WIDTH_IN){m[WIDTH_IN-1]}}, m};
    if (idx <= IDX_UNITY) restore = ext <<< (IDX_UNITY - idx);
    else                  restore = ext >>> (idx - IDX_UNITY);
  endfunction

  always_ff @(posedge clk) begin
    if (w_din_acc) begin
      for (int k = 0; k < ARRAY_IN; k++) begin
        r_s1_i[k]   <= din_i[k];
        r_s1_q[k]   <= din_q[k];
        r_s1_idx[k] <= (w_rd_idx[k] > IDX_CLAMP) ? IDX_CLAMP : w_rd_idx[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      dout_valid <= 1'b0;
      din_drop   <= 1'b0;
      for (int k = 0; k < ARRAY_IN; k++) begin
        dout_i[k] <= '0;
        dout_q[k] <= '0;
      end
    end else begin
      r_s1_valid <= w_din_acc;
      dout_valid <= r_s1_valid;
      din_drop   <= din_valid & ~din_ready;
      if (r_s1_valid) begin
        for (int k = 0; k < ARRAY_IN; k++) begin
          dout_i[k] <= restore(r_s1_i[k], r_s1_idx[k]);
          dout_q[k] <= restore(r_s1_q[k], r_s1_idx[k]);
        end
      end
    end
  end
endmodule

// File: tb/tb_fft_cbfp_denorm.sv
// Bench for fft_cbfp_denorm: directed table frames, reset/drop/ping-pong sequences and random
// frames, all scored against an arithmetic model with an index FIFO.
module tb_fft_cbfp_denorm;
  localparam int AI  = 16;
  localparam int NB  = 32;
  localparam int WI  = 12;
  localparam int WO  = 25;
  localparam int NS  = AI * NB;
  localparam int BW  = 2 * AI * WO;
  localparam int TMO = 300;
  localparam int NT  = 9;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 idx_valid = 1'b0;
  logic                 idx_ready;
  logic [4:0]           idx_in [0:AI-1];
  logic                 din_valid = 1'b0;
  logic                 din_ready;
  logic signed [WI-1:0] din_i [0:AI-1];
  logic signed [WI-1:0] din_q [0:AI-1];
  logic                 dout_valid;
  logic signed [WO-1:0] dout_i [0:AI-1];
  logic signed [WO-1:0] dout_q [0:AI-1];
  logic                 din_drop;
  logic                 dbg_rd_state;

  fft_cbfp_denorm #(.WIDTH_IN(WI), .WIDTH_OUT(WO), .ARRAY_IN(AI), .BEATS(NB)) dut (
    .clk(clk), .rst(rst),
    .idx_valid(idx_valid), .idx_ready(idx_ready), .idx_in(idx_in),
    .din_valid(din_valid), .din_ready(din_ready), .din_i(din_i), .din_q(din_q),
    .dout_valid(dout_valid), .dout_i(dout_i), .dout_q(dout_q),
    .din_drop(din_drop), .dbg_rd_state(dbg_rd_state)
  );

  // clock/reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [4:0]           idx;
    logic signed [WI-1:0] mi;
    logic signed [WI-1:0] mq;
    logic signed [WO-1:0] ei;
    logic signed [WO-1:0] eq;
  } vec_t;
  vec_t tbl [0:NT-1];
  logic use_table = 1'b0;

  logic [4:0]           idx_fr [0:3][0:NS-1];
  logic signed [WI-1:0] di_fr  [0:3][0:NS-1];
  logic signed [WI-1:0] dq_fr  [0:3][0:NS-1];

  // scoreboard state
  logic [BW-1:0] exp_q[$];
  int            ts_q[$];
  logic [4:0]    idx_q[$];
  int            m_frames = 0;
  int            m_wr = 0;
  int            m_rd = 0;
  logic          exp_drop = 1'b0;

  function automatic logic signed [WO-1:0] ref_restore(input int m, input int idx);
    int e, d, r;
    e = (idx > 24) ? 24 : idx;
    if (e <= 13) r = m * (1 << (13 - e));
    else begin
      d = 1 << (e - 13);
      r = (m >= 0) ? (m / d) : -(((-m) + d - 1) / d);
    end
    return WO'(r);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // monitor + model, sampled on the falling edge
  always @(negedge clk) begin
    logic [BW-1:0] act, e;
    logic          found;
    int            t, ix, s;
    logic signed [WO-1:0] vi, vq;
    if (dout_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL dout_unexpected: dout_valid=1 with nothing outstanding (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        t = ts_q.pop_front();
        for (int k = 0; k < AI; k++) begin
          act[(2*k)*WO +: WO]   = dout_i[k];
          act[(2*k+1)*WO +: WO] = dout_q[k];
        end
        if (act !== e) begin
          fails++;
          found = 1'b0;
          for (int k = 0; k < AI; k++) begin
            if (!found && act[(2*k)*WO +: 2*WO] !== e[(2*k)*WO +: 2*WO]) begin
              found = 1'b1;
              $display("FAIL dout_beat lane %0d: got i=%0d q=%0d expected i=%0d q=%0d (cycle %0d)",
                       k, $signed(act[(2*k)*WO +: WO]), $signed(act[(2*k+1)*WO +: WO]),
                       $signed(e[(2*k)*WO +: WO]), $signed(e[(2*k+1)*WO +: WO]), cyc);
            end
          end
        end
        checks++;
        if (cyc - t != 2) begin
          fails++;
          $display("FAIL dout_latency: got %0d cycles expected 2", cyc - t);
        end
      end
    end
    if (exp_drop || din_drop) begin
      checks++;
      if (din_drop !== exp_drop) begin
        fails++;
        $display("FAIL din_drop: got %0b expected %0b (cycle %0d)", din_drop, exp_drop, cyc);
      end
    end
    if (!rst) begin
      checks++;
      if (idx_ready !== (m_frames < 2)) begin
        fails++;
        $display("FAIL idx_ready: got %0b expected %0b (cycle %0d)", idx_ready, m_frames < 2, cyc);
      end
      if (m_frames == 0) begin
        checks++;
        if (din_ready !== 1'b0) begin
          fails++;
          $display("FAIL din_ready_no_frame: got %0b expected 0 (cycle %0d)", din_ready, cyc);
        end
      end
    end
    if (rst) begin
      exp_q.delete(); ts_q.delete(); idx_q.delete();
      m_frames = 0; m_wr = 0; m_rd = 0; exp_drop = 1'b0;
    end else begin
      exp_drop = din_valid && !din_ready;
      if (idx_valid && idx_ready) begin
        for (int k = 0; k < AI; k++) idx_q.push_back(idx_in[k]);
        m_wr++;
        if (m_wr == NB) begin m_wr = 0; m_frames++; end
      end
      if (din_valid && din_ready) begin
        for (int k = 0; k < AI; k++) begin
          ix = (idx_q.size() > 0) ? int'(idx_q.pop_front()) : 0;
          s  = m_rd * AI + k;
          if (use_table) begin
            vi = tbl[s % NT].ei;
            vq = tbl[s % NT].eq;
          end else begin
            vi = ref_restore(int'(din_i[k]), ix);
            vq = ref_restore(int'(din_q[k]), ix);
          end
          e[(2*k)*WO +: WO]   = vi;
          e[(2*k+1)*WO +: WO] = vq;
        end
        exp_q.push_back(e);
        ts_q.push_back(cyc);
        m_rd++;
        if (m_rd == NB) begin m_rd = 0; m_frames--; end
      end
    end
  end

  // driver tasks: called and return at posedge+1
  task automatic send_idx(input int f, input int nb, input int maxgap);
    for (int b = 0; b < nb; b++) begin
      int t;
      int g;
      g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
      if (g > 0) begin
        idx_valid = 1'b0;
        repeat (g) @(posedge clk);
        #1;
      end
      idx_valid = 1'b1;
      for (int k = 0; k < AI; k++) idx_in[k] = idx_fr[f][b*AI+k];
      t = 0;
      @(negedge clk);
      while (!idx_ready && t < TMO) begin @(negedge clk); t++; end
      if (t >= TMO) begin
        checks++; fails++;
        $display("FAIL idx_timeout: idx_ready stayed 0 for %0d cycles, expected 1", TMO);
        idx_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    idx_valid = 1'b0;
  endtask

  task automatic send_din(input int f, input int nb, input int maxgap);
    for (int b = 0; b < nb; b++) begin
      int t;
      int g;
      g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
      if (g > 0) begin
        din_valid = 1'b0;
        repeat (g) @(posedge clk);
        #1;
      end
      din_valid = 1'b1;
      for (int k = 0; k < AI; k++) begin
        din_i[k] = di_fr[f][b*AI+k];
        din_q[k] = dq_fr[f][b*AI+k];
      end
      t = 0;
      @(negedge clk);
      while (!din_ready && t < TMO) begin @(negedge clk); t++; end
      if (t >= TMO) begin
        checks++; fails++;
        $display("FAIL din_timeout: din_ready stayed 0 for %0d cycles, expected 1", TMO);
        din_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
  endtask

  task automatic fill_rand(input int f);
    for (int s = 0; s < NS; s++) begin
      idx_fr[f][s] = 5'($urandom_range(0, 31));
      di_fr[f][s]  = WI'($urandom);
      dq_fr[f][s]  = WI'($urandom);
    end
  endtask

  task automatic drain(input string name);
    repeat (4) @(posedge clk);
    #1;
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_state(input string name);
    logic any;
    any = 1'b0;
    for (int k = 0; k < AI; k++) any = any | (|dout_i[k]) | (|dout_q[k]);
    chk({name, "_idx_ready"}, 64'(idx_ready), 64'd1);
    chk({name, "_din_ready"}, 64'(din_ready), 64'd0);
    chk({name, "_dout_valid"}, 64'(dout_valid), 64'd0);
    chk({name, "_dout_zero"}, 64'(any), 64'd0);
    chk({name, "_rd_state"}, 64'(dbg_rd_state), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    for (int k = 0; k < AI; k++) begin idx_in[k] = '0; din_i[k] = '0; din_q[k] = '0; end
    tbl[0] = '{5'd13, -12'sd8,    12'sd7,    -25'sd8,     25'sd7};
    tbl[1] = '{5'd0,  12'h7FF,    12'h800,   25'h0FFE000, 25'h1000000};
    tbl[2] = '{5'd24, 12'h800,    12'h7FF,   -25'sd1,     25'sd0};
    tbl[3] = '{5'd31, 12'h800,    12'h7FF,   -25'sd1,     25'sd0};
    tbl[4] = '{5'd12, 12'sd3,     -12'sd3,   25'sd6,      -25'sd6};
    tbl[5] = '{5'd14, 12'sd3,     -12'sd3,   25'sd1,      -25'sd2};
    tbl[6] = '{5'd20, 12'sd1000,  -12'sd1000, 25'sd7,     -25'sd8};
    tbl[7] = '{5'd25, -12'sd1,    12'sd1,    -25'sd1,     25'sd0};
    tbl[8] = '{5'd1,  -12'sd1,    12'sd1,    -25'sd4096,  25'sd4096};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("por");
    @(posedge clk); #1;

    // unity index, lane ramp
    for (int s = 0; s < NS; s++) begin
      idx_fr[0][s] = 5'd13;
      di_fr[0][s]  = WI'((s % AI) - 8);
      dq_fr[0][s]  = WI'(7 - (s % AI));
    end
    send_idx(0, NB, 0);
    send_din(0, NB, 0);
    drain("unity_drain");

    // table-driven frame
    for (int s = 0; s < NS; s++) begin
      idx_fr[1][s] = tbl[s % NT].idx;
      di_fr[1][s]  = tbl[s % NT].mi;
      dq_fr[1][s]  = tbl[s % NT].mq;
    end
    use_table = 1'b1;
    send_idx(1, NB, 0);
    send_din(1, NB, 1);
    drain("table_drain");
    use_table = 1'b0;

    // din_valid with no frame available
    din_valid = 1'b1;
    @(negedge clk);
    chk("drop_not_ready", 64'(din_ready), 64'd0);
    @(posedge clk); #1 din_valid = 1'b0;
    @(negedge clk);
    chk("drop_pulse", 64'(din_drop), 64'd1);
    chk("drop_no_dout", 64'(dout_valid), 64'd0);
    @(negedge clk);
    chk("drop_clear", 64'(din_drop), 64'd0);
    @(posedge clk); #1;
    fill_rand(2);
    send_idx(2, NB, 0);
    send_din(2, NB, 0);
    drain("after_drop_drain");

    // reset mid-frame, with a partial index frame and data in flight
    fill_rand(0);
    fill_rand(1);
    send_idx(0, NB, 0);
    send_idx(1, 7, 0);
    send_din(0, 5, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("mid_rst");
    @(posedge clk); #1;
    fill_rand(3);
    send_idx(3, NB, 0);
    send_din(3, NB, 0);
    drain("post_rst_drain");

    // ping-pong: two index frames back to back, third waits for bank 0 release
    fill_rand(0);
    fill_rand(1);
    fill_rand(2);
    send_idx(0, NB, 0);
    send_idx(1, NB, 0);
    repeat (3) begin
      @(negedge clk);
      chk("pp_both_full", 64'(idx_ready), 64'd0);
    end
    @(posedge clk); #1;
    fork
      send_idx(2, NB, 0);
      begin
        send_din(0, NB, 0);
        send_din(1, NB, 0);
        send_din(2, NB, 0);
      end
    join
    drain("pp_drain");

    // random frames, concurrent writer/reader with random gaps
    for (int r = 0; r < 2; r++) begin
      for (int f = 0; f < 4; f++) fill_rand(f);
      fork
        for (int f = 0; f < 4; f++) send_idx(f, NB, 2);
        for (int f = 0; f < 4; f++) send_din(f, NB, 3);
      join
      drain("rand_drain");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
